alarm_controller: RTL and testbench

Read-side consumer of the alarm time register. Each cycle it compares the stored alarm time (4 BCD digits) against the running clock time. On a match it drives the buzzer, then handles the user's stop and snooze requests and an automatic ring timeout. It sits between the alarm register, the time counter and the speaker/LED drivers.

---
 rtl/alarm_pkg.sv | 16 +
 rtl/alarm_controller_countdown.sv | 30 +++
 rtl/alarm_controller.sv | 129 ++++++++++++
 tb/tb_alarm_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller.
// Holds the state encoding, BCD digit width and default minute lengths.
package alarm_pkg;

    localparam int BCD_W = 4;
    localparam int DEFAULT_SNOOZE_MIN = 5;
    localparam int DEFAULT_RING_TIMEOUT_MIN = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/alarm_controller_countdown.sv
// minute_countdown: 4-bit minute down-counter with load and expiry flag.
// Ports: clock, reset (sync, active-high), load, load_value[3:0],
//        one_minute (tick) -> count[3:0], expire.
module minute_countdown
    import alarm_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_value,
    input  logic             one_minute,
    output logic [BCD_W-1:0] count,
    output logic             expire
);

    // A tick in the load cycle is dropped; the count never goes below 1
    // by ticking, so it cannot wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (one_minute && count > 4'd1) begin
            count <= count - 4'd1;
        end
    end

    assign expire = one_minute && !load && (count == 4'd1);

endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: compares the alarm time with the running time and
// drives the buzzer, handling stop, snooze and automatic ring timeout.
// Ports: clock, reset (sync, active-high), one_minute, alarm_enable,
//        stop_alarm, snooze, alarm_time_* / current_time_* (BCD digits)
//        -> sound_alarm, snoozing (both decoded from the state register).
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN       = DEFAULT_SNOOZE_MIN,
    parameter int RING_TIMEOUT_MIN = DEFAULT_RING_TIMEOUT_MIN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             one_minute,
    input  logic             alarm_enable,
    input  logic             stop_alarm,
    input  logic             snooze,
    input  logic [BCD_W-1:0] alarm_time_ms_hr,
    input  logic [BCD_W-1:0] alarm_time_ls_hr,
    input  logic [BCD_W-1:0] alarm_time_ms_min,
    input  logic [BCD_W-1:0] alarm_time_ls_min,
    input  logic [BCD_W-1:0] current_time_ms_hr,
    input  logic [BCD_W-1:0] current_time_ls_hr,
    input  logic [BCD_W-1:0] current_time_ms_min,
    input  logic [BCD_W-1:0] current_time_ls_min,
    output logic             sound_alarm,
    output logic             snoozing
);

    localparam logic [BCD_W-1:0] SNOOZE_LOAD = BCD_W'(SNOOZE_MIN);
    localparam logic [BCD_W-1:0] RING_LOAD   = BCD_W'(RING_TIMEOUT_MIN);

    state_t           state;
    state_t           next_state;
    logic             match_q;
    logic             ring_load;
    logic             ring_tick;
    logic             ring_expire;
    logic             snz_load;
    logic             snz_tick;
    logic             snz_expire;
    logic [BCD_W-1:0] ring_count;
    logic [BCD_W-1:0] snz_count;
    logic             unused_counts;

    always_ff @(posedge clock) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= (alarm_time_ms_hr  == current_time_ms_hr)  &&
                       (alarm_time_ls_hr  == current_time_ls_hr)  &&
                       (alarm_time_ms_min == current_time_ms_min) &&
                       (alarm_time_ls_min == current_time_ls_min);
        end
    end

    // Counter controls mirror the FSM priorities so a counter only moves
    // when its transition would actually be taken.
    assign ring_tick = alarm_enable && (state == RINGING) &&
                       !stop_alarm && !snooze && one_minute;
    assign snz_tick  = alarm_enable && (state == SNOOZE) &&
                       !stop_alarm && one_minute;
    assign snz_load  = alarm_enable && (state == RINGING) &&
                       !stop_alarm && snooze;
    assign ring_load = alarm_enable &&
                       (((state == IDLE) && match_q) || snz_expire);

    minute_countdown u_ring (
        .clock      (clock),
        .reset      (reset),
        .load       (ring_load),
        .load_value (RING_LOAD),
        .one_minute (ring_tick),
        .count      (ring_count),
        .expire     (ring_expire)
    );

    minute_countdown u_snooze (
        .clock      (clock),
        .reset      (reset),
        .load       (snz_load),
        .load_value (SNOOZE_LOAD),
        .one_minute (snz_tick),
        .count      (snz_count),
        .expire     (snz_expire)
    );

    // Counts are only needed through the expire flags here.
    assign unused_counts = ^{ring_count, snz_count};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!alarm_enable) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (match_q) next_state = RINGING;
                end
                RINGING: begin
                    if (stop_alarm)       next_state = HOLD;
                    else if (snooze)      next_state = SNOOZE;
                    else if (ring_expire) next_state = HOLD;
                end
                SNOOZE: begin
                    if (stop_alarm)      next_state = HOLD;
                    else if (snz_expire) next_state = RINGING;
                end
                HOLD: begin
                    // Wait out the matching minute before re-arming.
                    if (!match_q) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign sound_alarm = (state == RINGING);
    assign snoozing    = (state == SNOOZE);

endmodule

// File: tb/tb_alarm_controller.sv
// Directed scoreboard bench for alarm_controller (default parameters).
// Expected outputs are queued with each step and checked after the edge.
module tb_alarm_controller;

    logic       clock;
    logic       reset;
    logic       one_minute;
    logic       alarm_enable;
    logic       stop_alarm;
    logic       snooze;
    logic [3:0] a_mh, a_lh, a_mm, a_lm;
    logic [3:0] c_mh, c_lh, c_mm, c_lm;
    logic       sound_alarm;
    logic       snoozing;

    typedef struct {
        string tag;
        logic  sa;
        logic  sn;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   failed;

    alarm_controller dut (
        .clock               (clock),
        .reset               (reset),
        .one_minute          (one_minute),
        .alarm_enable        (alarm_enable),
        .stop_alarm          (stop_alarm),
        .snooze              (snooze),
        .alarm_time_ms_hr    (a_mh),
        .alarm_time_ls_hr    (a_lh),
        .alarm_time_ms_min   (a_mm),
        .alarm_time_ls_min   (a_lm),
        .current_time_ms_hr  (c_mh),
        .current_time_ls_hr  (c_lh),
        .current_time_ms_min (c_mm),
        .current_time_ls_min (c_lm),
        .sound_alarm         (sound_alarm),
        .snoozing            (snoozing)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input string tag, input logic sa, input logic sn);
        exp_t e;
        e.tag = tag;
        e.sa  = sa;
        e.sn  = sn;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            failed++;
            $error("FAIL scoreboard: observed empty queue, expected entry");
        end else begin
            e = sb.pop_front();
            assert ({sound_alarm, snoozing} === {e.sa, e.sn})
            else begin
                failed++;
                $error("FAIL %s: observed sa=%0b sn=%0b expected sa=%0b sn=%0b",
                       e.tag, sound_alarm, snoozing, e.sa, e.sn);
            end
        end
    endtask

    task automatic step_check(input string tag, input logic sa,
                              input logic sn);
        push(tag, sa, sn);
        tick();
        check();
    endtask

    task automatic set_time(input logic [3:0] mh, input logic [3:0] lh,
                            input logic [3:0] mm, input logic [3:0] lm);
        c_mh = mh;
        c_lh = lh;
        c_mm = mm;
        c_lm = lm;
    endtask

    // Pulse one_minute for a single sampled edge and check right after it.
    task automatic minute(input string tag, input logic sa, input logic sn);
        one_minute = 1'b1;
        step_check(tag, sa, sn);
        one_minute = 1'b0;
        tick();
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        reset        = 1'b1;
        one_minute   = 1'b0;
        alarm_enable = 1'b0;
        stop_alarm   = 1'b0;
        snooze       = 1'b0;
        a_mh = 4'd0; a_lh = 4'd7; a_mm = 4'd3; a_lm = 4'd0;
        set_time(4'd0, 4'd7, 4'd3, 4'd0);
        tick();
        alarm_enable = 1'b1;
        step_check("reset_state", 1'b0, 1'b0);
        reset = 1'b0;
        set_time(4'd1, 4'd7, 4'd3, 4'd0);
        tick();
        tick();
        step_check("hr_digit_mismatch", 1'b0, 1'b0);

        // Trigger
        set_time(4'd0, 4'd7, 4'd2, 4'd9);
        tick();
        tick();
        step_check("idle_0729", 1'b0, 1'b0);
        set_time(4'd0, 4'd7, 4'd3, 4'd0);
        step_check("trig_edge1", 1'b0, 1'b0);
        step_check("trig_edge2", 1'b1, 1'b0);

        // Stop, then no re-ring inside the matching minute
        stop_alarm = 1'b1;
        step_check("stop", 1'b0, 1'b0);
        stop_alarm = 1'b0;
        repeat (100) tick();
        step_check("hold_no_rering", 1'b0, 1'b0);
        set_time(4'd0, 4'd7, 4'd3, 4'd1);
        repeat (3) tick();
        set_time(4'd0, 4'd7, 4'd3, 4'd0);
        step_check("rering_edge1", 1'b0, 1'b0);
        step_check("rering_edge2", 1'b1, 1'b0);

        // Snooze: held high has no further effect
        snooze = 1'b1;
        step_check("snooze_enter", 1'b0, 1'b1);
        step_check("snooze_held", 1'b0, 1'b1);
        snooze = 1'b0;
        for (int i = 0; i < 4; i++) minute("snooze_pulse", 1'b0, 1'b1);
        minute("snooze_end", 1'b1, 1'b0);

        // Timeout after RING_TIMEOUT_MIN pulses
        for (int i = 0; i < 9; i++) minute("ring_pulse", 1'b1, 1'b0);
        minute("timeout", 1'b0, 1'b0);
        repeat (50) tick();
        step_check("timeout_hold", 1'b0, 1'b0);
        set_time(4'd0, 4'd7, 4'd3, 4'd1);
        repeat (3) tick();
        set_time(4'd0, 4'd7, 4'd3, 4'd0);
        tick();
        step_check("ring_again", 1'b1, 1'b0);

        // Stop and snooze together: stop wins
        stop_alarm = 1'b1;
        snooze     = 1'b1;
        step_check("conflict", 1'b0, 1'b0);
        stop_alarm = 1'b0;
        snooze     = 1'b0;
        step_check("conflict_after", 1'b0, 1'b0);

        // Disable during snooze, then re-enable within the minute
        set_time(4'd0, 4'd7, 4'd3, 4'd1);
        repeat (3) tick();
        set_time(4'd0, 4'd7, 4'd3, 4'd0);
        tick();
        step_check("ring_for_disable", 1'b1, 1'b0);
        snooze = 1'b1;
        step_check("snooze_for_disable", 1'b0, 1'b1);
        snooze       = 1'b0;
        alarm_enable = 1'b0;
        step_check("disable", 1'b0, 1'b0);
        alarm_enable = 1'b1;
        step_check("reenable_rering", 1'b1, 1'b0);

        // Reset mid-ring with ring counter at 3
        for (int i = 0; i < 7; i++) minute("pre_reset_pulse", 1'b1, 1'b0);
        reset = 1'b1;
        step_check("reset_mid", 1'b0, 1'b0);
        reset = 1'b0;
        step_check("post_reset_match", 1'b0, 1'b0);
        // A pulse in the load cycle must not count
        one_minute = 1'b1;
        step_check("post_reset_ring", 1'b1, 1'b0);
        one_minute = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) minute("load_pulse", 1'b1, 1'b0);
        minute("load_timeout", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
